// File: rtl/uds_pkg.sv
// Shared types and width helpers for the UDS tile sequencer.
package uds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ACT,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // fmode[1] set selects upsample; otherwise fmode[0] picks avg over max
  localparam logic [1:0]  FMODE_MAX    = 2'b00;
  localparam logic [1:0]  FMODE_AVG    = 2'b01;
  localparam int unsigned FMODE_UP_BIT = 1;

  function automatic logic fmode_is_up(input logic [1:0] fmode);
    return fmode[FMODE_UP_BIT];
  endfunction

  function automatic int unsigned tile_w(input int unsigned a);
    return a * 32;
  endfunction

  function automatic int unsigned res_w(input int unsigned a);
    return 2 * (a - 8) * 32;
  endfunction

endpackage

// File: rtl/uds_result_buf.sv
// Single-entry valid/ready holding register for UDS results.
module uds_result_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         tout_valid,
  input  logic         tout_ready,
  output logic [W-1:0] tout_data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tout_valid <= 1'b0;
      tout_data  <= '0;
    end else if (load) begin
      tout_valid <= 1'b1;
      tout_data  <= load_data;
    end else if (tout_valid && tout_ready) begin
      tout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uds_tile_sequencer.sv
// Job-level controller feeding tiles through UDS and returning results.
// Optional perf counters enabled by defining UDS_SEQ_PERF_EN.
module uds_tile_sequencer
  import uds_pkg::*;
#(
  parameter int unsigned A        = 64,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_start,
  output logic                   job_ready,
  input  logic [1:0]             job_fmode,
  input  logic [1:0]             job_scale,
  input  logic [CNT_W-1:0]       job_ntiles,
  input  logic                   tin_valid,
  output logic                   tin_ready,
  input  logic [tile_w(A)-1:0]   tin_data,
  output logic [tile_w(A)-1:0]   uds_idata,
  output logic                   uds_idata_valid,
  output logic                   uds_active,
  output logic [1:0]             uds_fmode,
  output logic [1:0]             uds_scale,
  input  logic [res_w(A)-1:0]    uds_odata,
  input  logic                   uds_odata_valid,
  output logic                   tout_valid,
  input  logic                   tout_ready,
  output logic [res_w(A)-1:0]    tout_data,
  output logic                   job_done,
  output logic                   job_err
`ifdef UDS_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_busy_cyc,
  output logic [31:0]            perf_stall_cyc
`endif
);

  localparam int unsigned WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  seq_state_e       state;
  logic [CNT_W-1:0] ntiles_q;
  logic [CNT_W-1:0] tiles_done;
  logic [CNT_W-1:0] tiles_next;
  logic [WC_W-1:0]  wait_cnt;
  logic             buf_load;

  assign tiles_next = tiles_done + CNT_W'(1);
  assign buf_load   = (state == ST_WAIT) && uds_odata_valid;

  uds_result_buf #(.W(res_w(A))) u_result_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .load_data  (uds_odata),
    .tout_valid (tout_valid),
    .tout_ready (tout_ready),
    .tout_data  (tout_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      job_ready       <= 1'b1;
      tin_ready       <= 1'b0;
      uds_idata       <= '0;
      uds_idata_valid <= 1'b0;
      uds_active      <= 1'b0;
      uds_fmode       <= '0;
      uds_scale       <= '0;
      job_done        <= 1'b0;
      job_err         <= 1'b0;
      ntiles_q        <= '0;
      tiles_done      <= '0;
      wait_cnt        <= '0;
    end else begin
      job_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_start) begin
            uds_fmode  <= job_fmode;
            uds_scale  <= job_scale;
            ntiles_q   <= job_ntiles;
            tiles_done <= '0;
            job_err    <= 1'b0;
            job_ready  <= 1'b0;
            if (job_ntiles == '0) begin
              state    <= ST_DONE;
              job_done <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              tin_ready <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (tin_valid) begin
            uds_idata       <= tin_data;
            tin_ready       <= 1'b0;
            uds_idata_valid <= 1'b1;
            state           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          uds_idata_valid <= 1'b0;
          uds_active      <= 1'b1;
          state           <= ST_ACT;
        end
        ST_ACT: begin
          uds_active <= 1'b0;
          wait_cnt   <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // result capture itself happens in the buffer via buf_load
          if (uds_odata_valid) begin
            state <= ST_DRAIN;
          end else if (wait_cnt == WC_W'(WAIT_MAX - 1)) begin
            job_err  <= 1'b1;
            job_done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ST_DRAIN: begin
          if (tout_valid && tout_ready) begin
            tiles_done <= tiles_next;
            if (tiles_next == ntiles_q) begin
              state    <= ST_DONE;
              job_done <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              tin_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          job_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          job_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef UDS_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (state == ST_IDLE && job_start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state != ST_IDLE && perf_busy_cyc != '1)
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (((state == ST_FETCH && !tin_valid) || (state == ST_DRAIN && !tout_ready)) &&
          perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule
